// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The producer and consumer side drives through master; the subtractor connects to slave.
interface serial_subtractor_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] diff;
   logic         bout;
   logic         busy;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, busy
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, busy
   );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first,
// with the borrow rippling between slices exactly like a ripple-borrow chain.
module serial_subtractor #(
   parameter int N     = 8,
   parameter int DIGIT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus
);
   localparam int NSL   = N / DIGIT;
   localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if ((DIGIT < 1) || ((N % DIGIT) != 0)) begin : g_bad_digit
         $error("serial_subtractor: DIGIT must be >= 1 and divide N");
      end
   endgenerate

   // Returns {borrow_out, difference} for one DIGIT-wide slice; the sign bit is the borrow.
   function automatic logic [DIGIT:0] sub_slice(
      input logic [DIGIT-1:0] x,
      input logic [DIGIT-1:0] y,
      input logic             bi
   );
      sub_slice = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
   endfunction

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [N-1:0]     a_r;
   logic [N-1:0]     b_r;
   logic             borrow_r;
   logic [N-1:0]     diff_r;
   logic             bout_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [DIGIT:0]   slice_s;
   logic             last_s;

   // Current slice result and end-of-operand detection.
   always_comb begin
      slice_s = sub_slice(a_r[cnt_r*DIGIT +: DIGIT], b_r[cnt_r*DIGIT +: DIGIT], borrow_r);
      last_s  = (cnt_r == CNT_W'(NSL - 1));
   end

   // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.in_valid) state_s = S_RUN;
            else              state_s = S_IDLE;
         end
         S_RUN: begin
            if (last_s) state_s = S_DONE;
            else        state_s = S_RUN;
         end
         S_DONE: begin
            if (bus.out_ready) state_s = S_IDLE;
            else               state_s = S_DONE;
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State, datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         cnt_r       <= '0;
         a_r         <= '0;
         b_r         <= '0;
         borrow_r    <= 1'b0;
         diff_r      <= '0;
         bout_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == S_IDLE);
         out_valid_r <= (state_s == S_DONE);
         busy_r      <= (state_s != S_IDLE);
         case (state_r)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_r      <= bus.a;
                  b_r      <= bus.b;
                  borrow_r <= bus.bin;
                  cnt_r    <= '0;
               end
            end
            S_RUN: begin
               diff_r[cnt_r*DIGIT +: DIGIT] <= slice_s[DIGIT-1:0];
               borrow_r                     <= slice_s[DIGIT];
               // Counter parks at zero after the final slice so it never passes NSL-1.
               if (last_s) begin
                  bout_r <= slice_s[DIGIT];
                  cnt_r  <= '0;
               end else begin
                  cnt_r  <= cnt_r + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.diff      = diff_r;
   assign bus.bout      = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at (N,DIGIT) = (8,1), (8,4) and (16,2).
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.N(8))  if0 ();
   serial_subtractor_if #(.N(8))  if1 ();
   serial_subtractor_if #(.N(16)) if2 ();

   serial_subtractor #(.N(8),  .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   serial_subtractor #(.N(8),  .DIGIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   serial_subtractor #(.N(16), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   logic [7:0] v_a    [0:3] = '{8'h00, 8'h10, 8'h80, 8'h00};
   logic [7:0] v_b    [0:3] = '{8'h01, 8'h10, 8'h7F, 8'hFF};
   logic       v_bin  [0:3] = '{1'b0, 1'b1, 1'b1, 1'b1};
   logic [7:0] v_diff [0:3] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
   logic       v_bout [0:3] = '{1'b1, 1'b1, 1'b0, 1'b1};

   // Offer one operand set to dut0, scramble the inputs after accept, wait for out_valid.
   task automatic drive8(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin, output int lat);
      @(negedge clk);
      if0.a = ta; if0.b = tbv; if0.bin = tbin; if0.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.in_valid = 1'b0; if0.a = ~ta; if0.b = ~tbv; if0.bin = ~tbin;
      lat = 0;
      while (!if0.out_valid && lat < 40) begin
         @(posedge clk); lat++; @(negedge clk);
      end
   endtask

   task automatic release8();
      if0.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (if0.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", if0.in_ready); end
      n_cmp++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", if0.out_valid); end
      n_cmp++; if (if0.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", if0.busy); end
      n_cmp++; if (if0.diff !== 8'h00)     begin n_err++; $display("FAIL reset_diff got %h want 00", if0.diff); end
      n_cmp++; if (if0.bout !== 1'b0)      begin n_err++; $display("FAIL reset_bout got %b want 0", if0.bout); end
   endtask

   task automatic test_basic();
      int lat;
      drive8(8'h05, 8'h03, 1'b0, lat);
      n_cmp++; if (lat !== 8)           begin n_err++; $display("FAIL basic_latency got %0d want 8", lat); end
      n_cmp++; if (if0.diff !== 8'h02)  begin n_err++; $display("FAIL basic_diff got %h want 02", if0.diff); end
      n_cmp++; if (if0.bout !== 1'b0)   begin n_err++; $display("FAIL basic_bout got %b want 0", if0.bout); end
      n_cmp++; if (if0.busy !== 1'b1)   begin n_err++; $display("FAIL basic_busy_done got %b want 1", if0.busy); end
      release8();
      n_cmp++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_ov_fall got %b want 0", if0.out_valid); end
      n_cmp++; if (if0.in_ready !== 1'b1)  begin n_err++; $display("FAIL basic_ready_back got %b want 1", if0.in_ready); end
      n_cmp++; if (if0.diff !== 8'h02)     begin n_err++; $display("FAIL basic_diff_hold got %h want 02", if0.diff); end
   endtask

   task automatic test_borrow();
      int lat;
      for (int i = 0; i < 4; i++) begin
         drive8(v_a[i], v_b[i], v_bin[i], lat);
         n_cmp++;
         if ({if0.bout, if0.diff} !== {v_bout[i], v_diff[i]}) begin
            n_err++;
            $display("FAIL borrow_vec%0d got bout=%b diff=%h want bout=%b diff=%h", i, if0.bout, if0.diff, v_bout[i], v_diff[i]);
         end
         release8();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      drive8(8'h37, 8'h15, 1'b0, lat);
      for (int c = 0; c < 5; c++) begin
         if0.in_valid = 1'b1; if0.a = 8'hAA; if0.b = 8'h01; if0.bin = 1'b0;
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if ({if0.out_valid, if0.in_ready, if0.bout, if0.diff} !== {1'b1, 1'b0, 1'b0, 8'h22}) begin
            n_err++;
            $display("FAIL bp_hold_c%0d got ov=%b rdy=%b bout=%b diff=%h want ov=1 rdy=0 bout=0 diff=22",
                     c, if0.out_valid, if0.in_ready, if0.bout, if0.diff);
         end
      end
      if0.in_valid = 1'b0;
      release8();
      n_cmp++;
      if ({if0.out_valid, if0.in_ready, if0.busy} !== 3'b010) begin
         n_err++;
         $display("FAIL bp_release got ov/rdy/busy=%b want 010", {if0.out_valid, if0.in_ready, if0.busy});
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      @(negedge clk);
      if0.a = 8'h44; if0.b = 8'h11; if0.bin = 1'b0; if0.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before got %b want 1", if0.busy); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({if0.in_ready, if0.out_valid, if0.busy, if0.bout, if0.diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL rmid_outputs got rdy=%b ov=%b busy=%b bout=%b diff=%h want 1 0 0 0 00",
                  if0.in_ready, if0.out_valid, if0.busy, if0.bout, if0.diff);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); @(negedge clk);
         if (if0.out_valid) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rmid_no_pulse got %0d pulses want 0", seen); end
      drive8(8'h20, 8'h01, 1'b0, lat);
      n_cmp++;
      if ({lat[7:0], if0.bout, if0.diff} !== {8'd8, 1'b0, 8'h1F}) begin
         n_err++;
         $display("FAIL rmid_next got lat=%0d bout=%b diff=%h want lat=8 bout=0 diff=1f", lat, if0.bout, if0.diff);
      end
      release8();
   endtask

   task automatic test_back_to_back();
      int t1;
      int t2;
      t1 = -1; t2 = -1;
      @(negedge clk);
      if0.a = 8'h09; if0.b = 8'h04; if0.bin = 1'b0; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); @(negedge clk);
         if (if0.out_valid) begin
            if (t1 < 0)      t1 = c;
            else if (t2 < 0) t2 = c;
            n_cmp++;
            if (if0.diff !== 8'h05) begin n_err++; $display("FAIL b2b_diff got %h want 05", if0.diff); end
         end
      end
      n_cmp++; if (t2 - t1 !== 10) begin n_err++; $display("FAIL b2b_period got %0d want 10", t2 - t1); end
      if0.in_valid = 1'b0;
      repeat (15) @(negedge clk);
      if0.out_ready = 1'b0;
   endtask

   task automatic test_random_d4();
      logic [7:0] ra, rb;
      logic       rbin;
      logic [8:0] exp;
      int         lat;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         exp = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
         @(negedge clk);
         if1.a = ra; if1.b = rb; if1.bin = rbin; if1.in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         if1.in_valid = 1'b0; if1.a = 8'($urandom); if1.b = 8'($urandom);
         lat = 0;
         while (!if1.out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
         n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL d4_latency vec%0d got %0d want 2", i, lat); end
         repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
         n_cmp++;
         if ({if1.bout, if1.diff} !== exp) begin
            n_err++;
            $display("FAIL d4_result vec%0d a=%h b=%h bin=%b got %h want %h", i, ra, rb, rbin, {if1.bout, if1.diff}, exp);
         end
         if1.out_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         if1.out_ready = 1'b0;
      end
   endtask

   task automatic test_random_d2();
      logic [15:0] ra, rb;
      logic        rbin;
      logic [16:0] exp;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
         exp = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
         @(negedge clk);
         if2.a = ra; if2.b = rb; if2.bin = rbin; if2.in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         if2.in_valid = 1'b0; if2.a = 16'($urandom); if2.b = 16'($urandom);
         lat = 0;
         while (!if2.out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
         n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL d2_latency vec%0d got %0d want 8", i, lat); end
         repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
         n_cmp++;
         if ({if2.bout, if2.diff} !== exp) begin
            n_err++;
            $display("FAIL d2_result vec%0d a=%h b=%h bin=%b got %h want %h", i, ra, rb, rbin, {if2.bout, if2.diff}, exp);
         end
         if2.out_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         if2.out_ready = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      if0.in_valid = 1'b0; if0.a = 8'h00;  if0.b = 8'h00;  if0.bin = 1'b0; if0.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.a = 8'h00;  if1.b = 8'h00;  if1.bin = 1'b0; if1.out_ready = 1'b0;
      if2.in_valid = 1'b0; if2.a = 16'h0;  if2.b = 16'h0;  if2.bin = 1'b0; if2.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_borrow();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random_d4();
      test_random_d2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
